mcs4_bus_monitor: RTL

//  Passive listener on the shared MCS-4 4-bit data bus: the receiving end of the 4004's 8-phase instruction-cycle protocol.

---
 rtl/mcs4_bus_monitor.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mcs4_bus_monitor.sv
// Passive MCS-4 bus listener: follows the 4004 eight-phase instruction cycle from sync,
// rebuilds {x2, opr, opa, addr} for each cycle and queues it in a first-word-fall-through trace FIFO.
module mcs4_bus_monitor #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          sync,
  input  logic [3:0]                    dbus,
  input  logic                          cm_rom,
  input  logic [3:0]                    cm_ram,
  output logic [23:0]                   trace_data,
  output logic                          trace_valid,
  input  logic                          trace_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              drop_cnt,
  output logic [CNT_W-1:0]              sync_err_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [3:0] {
    PH_IDLE,
    PH_A1,
    PH_A2,
    PH_A3,
    PH_M1,
    PH_M2,
    PH_X1,
    PH_X2,
    PH_X3
  } phase_t;

  phase_t            phase;
  phase_t            phase_nxt;
  logic              sync_err;

  logic [11:0]       addr_q;
  logic [3:0]        opr_q;
  logic [3:0]        opa_q;

  logic [23:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;

  logic              push_req;
  logic              fifo_full;
  logic              push_ok;
  logic              push_drop;
  logic              pop;
  logic [23:0]       record;

  // Command lines are reserved for future bank tagging; folded here so they stay observed but inert.
  logic              unused_cm;
  assign unused_cm = ^{cm_rom, cm_ram};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= PH_IDLE;
    end else begin
      phase <= phase_nxt;
    end
  end

  // sync always restarts at A1; it is only legitimate while idle or in X3.
  always_comb begin
    phase_nxt = PH_IDLE;
    sync_err  = 1'b0;
    if (sync) begin
      phase_nxt = PH_A1;
      sync_err  = (phase != PH_IDLE) && (phase != PH_X3);
    end else begin
      case (phase)
        PH_IDLE: phase_nxt = PH_IDLE;
        PH_A1:   phase_nxt = PH_A2;
        PH_A2:   phase_nxt = PH_A3;
        PH_A3:   phase_nxt = PH_M1;
        PH_M1:   phase_nxt = PH_M2;
        PH_M2:   phase_nxt = PH_X1;
        PH_X1:   phase_nxt = PH_X2;
        PH_X2:   phase_nxt = PH_X3;
        PH_X3: begin
          phase_nxt = PH_IDLE;
          sync_err  = 1'b1;
        end
        default: phase_nxt = PH_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      opr_q  <= '0;
      opa_q  <= '0;
    end else begin
      case (phase)
        PH_A1:   addr_q[3:0]  <= dbus;
        PH_A2:   addr_q[7:4]  <= dbus;
        PH_A3:   addr_q[11:8] <= dbus;
        PH_M1:   opr_q        <= dbus;
        PH_M2:   opa_q        <= dbus;
        default: ;
      endcase
    end
  end

  // The X2 nibble goes straight from the bus into the record, so a cycle aborted by sync in X2 never pushes.
  assign record    = {dbus, opr_q, opa_q, addr_q};
  assign push_req  = (phase == PH_X2) && !sync && en;
  assign fifo_full = (level == LVL_W'(FIFO_DEPTH));
  assign push_ok   = push_req && !fifo_full;
  assign push_drop = push_req && fifo_full;
  assign pop       = trace_valid && trace_ready;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= record;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt     <= '0;
      sync_err_cnt <= '0;
    end else begin
      if (push_drop && (drop_cnt != '1)) begin
        drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (sync_err && (sync_err_cnt != '1)) begin
        sync_err_cnt <= sync_err_cnt + CNT_W'(1);
      end
    end
  end

  assign trace_valid = (level != '0);
  assign trace_data  = trace_valid ? mem[rd_ptr] : 24'h0;
  assign fifo_level  = level;

endmodule
